// File: rtl/inexrecur_pkg.sv
// Shared types and helpers for the inexact-recursion frame fetch block.
//   AW, DW, FW : regfile address width, entry width, field width
//   state_t    : fetch controller state encoding (also the debug view)
//   frame_t    : one unpacked frame {addr, f3, f2, f1, f0}
//   get_field / unpack_frame : byte-field extraction from a regfile entry
package inexrecur_pkg;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int FW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [FW-1:0] f3;
        logic [FW-1:0] f2;
        logic [FW-1:0] f1;
        logic [FW-1:0] f0;
    } frame_t;

    // Field idx 3 is the most significant byte of the entry.
    function automatic logic [FW-1:0] get_field(input logic [DW-1:0] word, input int idx);
        return word[idx*FW +: FW];
    endfunction

    function automatic frame_t unpack_frame(input logic [AW-1:0] addr, input logic [DW-1:0] word);
        frame_t f;
        f.addr = addr;
        f.f3   = get_field(word, 3);
        f.f2   = get_field(word, 2);
        f.f1   = get_field(word, 1);
        f.f0   = get_field(word, 0);
        return f;
    endfunction

endpackage

// File: rtl/inexrecur_skid_buf.sv
// BUF_D-deep FIFO of frame_t used as the skid buffer between the regfile
// return path and the engine handshake. There is no overflow guard: the
// producer's credit logic never pushes into a full buffer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail this cycle
//   push_data  : frame to write
//   pop        : drop the head this cycle (only when occ != 0)
//   head       : current head entry (all zero after reset)
//   occ        : number of stored entries
module inexrecur_skid_buf
    import inexrecur_pkg::*;
#(
    parameter int BUF_D = 2,
    parameter int OW    = $clog2(BUF_D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  frame_t        push_data,
    input  logic          pop,
    output frame_t        head,
    output logic [OW-1:0] occ
);

    localparam int PW = $clog2(BUF_D);

    frame_t        mem [BUF_D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_D - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_D; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inexrecur_frame_fetch.sv
// Drains entry_cnt entries from the regfile sequential read port, unpacks
// each into four byte fields and presents them to the inexact-recursion
// engine in order, with no drops or duplicates.
// Optional feature macro: INEXRECUR_FETCH_CHK_EN adds a sticky address
// continuity / range check on output err.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : one-cycle pulse, accepted only in IDLE
//   entry_cnt       : entries to fetch, sampled on an accepted start
//   busy            : from the accepted start until done
//   done            : one-cycle pulse after the last frame handshake
//   seq_re          : regfile sequential read enable
//   seq_r_data      : regfile data, valid the cycle after seq_re
//   out_r_addr      : regfile address of seq_r_data, same timing
//   frame_valid/ready, frame_addr, frame_f3..f0 : frame output
//   dbg_state       : current controller state (state_t encoding)
//   err             : (INEXRECUR_FETCH_CHK_EN only) sticky check flag
//
// Handshake: a frame transfers in every cycle where frame_valid && frame_ready
// are both high at the rising edge. frame_valid never drops and frame_* never
// change while a frame is waiting (valid && !ready).
module inexrecur_frame_fetch
    import inexrecur_pkg::*;
#(
    parameter int BUF_D = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] entry_cnt,
    output logic          busy,
    output logic          done,
    output logic          seq_re,
    input  logic [DW-1:0] seq_r_data,
    input  logic [AW-1:0] out_r_addr,
    output logic          frame_valid,
    input  logic          frame_ready,
    output logic [AW-1:0] frame_addr,
    output logic [FW-1:0] frame_f3,
    output logic [FW-1:0] frame_f2,
    output logic [FW-1:0] frame_f1,
    output logic [FW-1:0] frame_f0,
    output logic [1:0]    dbg_state
`ifdef INEXRECUR_FETCH_CHK_EN
    ,
    output logic          err
`endif
);

    localparam int CW = AW + 1;
    localparam int OW = $clog2(BUF_D + 1);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic [CW-1:0] issued;
    logic [CW-1:0] recvd;
    logic          inflight;
    logic          start_ok;
    logic          push;
    logic          pop;
    logic          room;
    logic          issue_left;
    logic          last_pop;
    logic [OW-1:0] occ;
    frame_t        head;

    assign start_ok   = start && (state == IDLE);
    assign push       = inflight;
    assign pop        = frame_valid && frame_ready;
    assign issue_left = issued < {1'b0, cnt};
    // The final frame leaves when everything has returned and it is alone.
    assign last_pop   = pop && (occ == OW'(1)) && (recvd == {1'b0, cnt});

    // Credit: the entry requested now lands next cycle, on top of what is
    // stored after this cycle's pop plus whatever is already in flight.
    // Counting the pop keeps one frame per cycle with ready held high, and a
    // low ready removes that credit in the same cycle.
    assign room = (int'(occ) - int'(pop) + int'(inflight)) < BUF_D;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (entry_cnt != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (issued + CW'(seq_re) == {1'b0, cnt}) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. busy includes the cycle start is accepted so that a zero-count
    // start shows busy for one cycle ahead of the done pulse.
    always_comb begin
        seq_re = (state == FETCH) && issue_left && room;
        busy   = (state == FETCH) || (state == DRAIN) || start_ok;
        done   = (state == DONE);
    end

    assign dbg_state = state;

    // Counters and in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            issued   <= '0;
            recvd    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= seq_re;
            if (start_ok) begin
                cnt    <= entry_cnt;
                issued <= '0;
                recvd  <= '0;
            end else begin
                if (seq_re) begin
                    issued <= issued + CW'(1);
                end
                if (push) begin
                    recvd <= recvd + CW'(1);
                end
            end
        end
    end

    inexrecur_skid_buf #(
        .BUF_D (BUF_D),
        .OW    (OW)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (unpack_frame(out_r_addr, seq_r_data)),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign frame_valid = (occ != '0);
    assign frame_addr  = head.addr;
    assign frame_f3    = head.f3;
    assign frame_f2    = head.f2;
    assign frame_f1    = head.f1;
    assign frame_f0    = head.f0;

`ifdef INEXRECUR_FETCH_CHK_EN
    // The first returned address becomes the base; every later entry must
    // follow it contiguously, and the run must fit below the top address.
    logic [AW-1:0] base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err  <= 1'b0;
            base <= '0;
        end else if (start_ok) begin
            err <= 1'b0;
        end else if (push) begin
            if (recvd == '0) begin
                base <= out_r_addr;
                if ({1'b0, cnt} > ({1'b0, {AW{1'b1}}} - {1'b0, out_r_addr})) begin
                    err <= 1'b1;
                end
            end else if (out_r_addr != base + recvd[AW-1:0]) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule
